// File: rtl/vote_session_ctrl_pkg.sv
// vote_session_ctrl_pkg: shared state enum, sizes and helpers for the vote session controller
package vote_session_ctrl_pkg;
  localparam int NUM_CAND = 4;
  localparam int ID_W = 4;
  typedef enum logic [2:0] {IDLE, CHECK, RESULT, VOTE, COMMIT} state_t;
  function automatic logic is_onehot(input logic [NUM_CAND-1:0] v);
    return (v != '0) && ((v & (v - NUM_CAND'(1))) == '0);
  endfunction
endpackage

// File: rtl/vote_session_ctrl_tally_bank.sv
// vote_tally_bank: four saturating per-candidate tallies with one-hot increment and readout mux
module vote_tally_bank
  import vote_session_ctrl_pkg::*;
#(
  parameter int TALLY_W = 8
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                inc,
  input  logic [NUM_CAND-1:0] sel,
  input  logic [1:0]          rd_sel,
  output logic [TALLY_W-1:0]  q
);
  logic [TALLY_W-1:0] tally [NUM_CAND];
  // count one vote for the selected candidate, holding at full scale
  always_ff @(posedge clk)
    for (int i = 0; i < NUM_CAND; i++)
      if (reset) tally[i] <= '0;
      else if (inc && sel[i] && tally[i] != '1) tally[i] <= tally[i] + TALLY_W'(1);
  assign q = tally[rd_sel];
endmodule

// File: rtl/vote_session_ctrl.sv
// vote_session_ctrl: voter session FSM driving an external ID checker and a tally bank
module vote_session_ctrl
  import vote_session_ctrl_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 1000,
  parameter int TALLY_W = 8
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                poll_open,
  input  logic                id_load,
  input  logic [ID_W-1:0]     id_in,
  input  logic [NUM_CAND-1:0] vote_btn,
  output logic [ID_W-1:0]     chk_id,
  output logic                chk_check,
  output logic                chk_mark_done,
  input  logic                chk_id_valid,
  input  logic                chk_id_used,
  output logic                busy,
  output logic                accepted,
  output logic                rejected,
  output logic                timed_out,
  input  logic [1:0]          tally_sel,
  output logic [TALLY_W-1:0]  tally_q
);
  localparam logic [15:0] LAST = 16'(TIMEOUT_CYCLES - 1);
  state_t state;
  logic [15:0] timer;
  logic btn_ok, inc;
  assign btn_ok = is_onehot(vote_btn);
  assign inc = (state == VOTE) && btn_ok;
  assign busy = state != IDLE;
  // session sequencing; strobes and status pulses are registered and last one cycle
  always_ff @(posedge clk)
    if (reset) begin
      state <= IDLE;
      chk_id <= '0;
      timer <= '0;
      chk_check <= 1'b0;
      chk_mark_done <= 1'b0;
      accepted <= 1'b0;
      rejected <= 1'b0;
      timed_out <= 1'b0;
    end else begin
      chk_check <= 1'b0;
      chk_mark_done <= 1'b0;
      accepted <= 1'b0;
      rejected <= 1'b0;
      timed_out <= 1'b0;
      case (state)
        IDLE: if (id_load && poll_open) begin
          chk_id <= id_in;
          chk_check <= 1'b1;
          state <= CHECK;
        end
        CHECK: state <= RESULT;
        RESULT: if (chk_id_valid && !chk_id_used) begin
          timer <= '0;
          state <= VOTE;
        end else begin
          rejected <= 1'b1;
          state <= IDLE;
        end
        VOTE: if (btn_ok) begin
          accepted <= 1'b1;
          chk_mark_done <= 1'b1;
          state <= COMMIT;
        end else if (timer == LAST) begin
          timed_out <= 1'b1;
          state <= IDLE;
        end else timer <= timer + 16'd1;
        COMMIT: state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  vote_tally_bank #(.TALLY_W(TALLY_W)) u_bank (
    .clk(clk), .reset(reset), .inc(inc), .sel(vote_btn), .rd_sel(tally_sel), .q(tally_q)
  );
endmodule

// File: tb/tb_vote_session_ctrl.sv
// tb_vote_session_ctrl: table-driven session checks plus reset, poll-closed and saturation sequences
module tb_vote_session_ctrl;
  localparam int TO = 8;
  localparam int ACC = 1, REJ = 2, TMO = 3;
  logic clk = 0, reset = 1, poll_open = 1, id_load = 0;
  logic [3:0] id_in = '0, vote_btn = '0;
  logic chk_id_valid = 0, chk_id_used = 0;
  logic [1:0] tally_sel = '0;
  logic [3:0] chk_id, d2_chk_id;
  logic chk_check, chk_mark_done, busy, accepted, rejected, timed_out;
  logic d2_chk_check, d2_mark, d2_busy, d2_acc, d2_rej, d2_to;
  logic [7:0] tally_q;
  logic [1:0] d2_tally_q;
  int n_checks = 0, n_fail = 0;
  bit used [16];
  bit silent = 0, resp_prev = 0;
  typedef struct {
    logic [3:0] id;
    logic [3:0] b1, b2;
    int sw;
    bit drop, silent;
    int outc, cyc;
    int t[4];
  } vec_t;
  vec_t tbl [11];
  always #5 clk = ~clk;
  vote_session_ctrl #(.TIMEOUT_CYCLES(TO), .TALLY_W(8)) dut (
    .clk(clk), .reset(reset), .poll_open(poll_open), .id_load(id_load), .id_in(id_in),
    .vote_btn(vote_btn), .chk_id(chk_id), .chk_check(chk_check), .chk_mark_done(chk_mark_done),
    .chk_id_valid(chk_id_valid), .chk_id_used(chk_id_used), .busy(busy), .accepted(accepted),
    .rejected(rejected), .timed_out(timed_out), .tally_sel(tally_sel), .tally_q(tally_q)
  );
  vote_session_ctrl #(.TIMEOUT_CYCLES(TO), .TALLY_W(2)) dut2 (
    .clk(clk), .reset(reset), .poll_open(poll_open), .id_load(id_load), .id_in(id_in),
    .vote_btn(vote_btn), .chk_id(d2_chk_id), .chk_check(d2_chk_check), .chk_mark_done(d2_mark),
    .chk_id_valid(chk_id_valid), .chk_id_used(chk_id_used), .busy(d2_busy), .accepted(d2_acc),
    .rejected(d2_rej), .timed_out(d2_to), .tally_sel(tally_sel), .tally_q(d2_tally_q)
  );
  // ID checker model: answers during the cycle after the check strobe, remembers marked IDs
  always @(negedge clk) begin
    chk_id_valid = resp_prev && !silent && !used[chk_id];
    chk_id_used = resp_prev && !silent && used[chk_id];
    resp_prev = chk_check;
    if (chk_mark_done) used[chk_id] = 1;
    if (reset) used = '{default: 0};
  end
  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask
  task automatic chk_tallies(input string tag, input int e0, e1, e2, e3);
    int e [4];
    e = '{e0, e1, e2, e3};
    for (int s = 0; s < 4; s++) begin
      tally_sel = 2'(s);
      #1;
      chk($sformatf("%s tally%0d", tag, s), int'(tally_q), e[s]);
    end
    tally_sel = '0;
  endtask
  task automatic run_vec(input string tag, input vec_t v);
    int first, fcyc, npulse, nmark, mark_id, chk_cyc;
    first = 0; fcyc = 0; npulse = 0; nmark = 0; mark_id = -1; chk_cyc = -1;
    silent = v.silent;
    id_in = v.id; id_load = 1; vote_btn = v.b1;
    for (int k = 1; k <= TO + 6; k++) begin
      @(negedge clk);
      if (chk_check && chk_cyc < 0) chk_cyc = k;
      npulse += int'(accepted) + int'(rejected) + int'(timed_out);
      if (first == 0 && (accepted || rejected || timed_out)) begin
        first = accepted ? ACC : rejected ? REJ : TMO;
        fcyc = k;
      end
      if (chk_mark_done) begin nmark++; mark_id = int'(chk_id); end
      if (k == 1) begin id_load = 0; if (v.drop) poll_open = 0; end
      if (k == 2) begin id_load = 1; id_in = ~v.id; end
      if (k == 3) id_load = 0;
      if (k == v.sw) vote_btn = v.b2;
    end
    chk({tag, " outcome"}, first, v.outc);
    chk({tag, " pulse cycle"}, fcyc, v.cyc);
    chk({tag, " pulse count"}, npulse, 1);
    chk({tag, " chk_check cycle"}, chk_cyc, 1);
    chk({tag, " mark_done count"}, nmark, v.outc == ACC ? 1 : 0);
    if (v.outc == ACC) chk({tag, " mark_done id"}, mark_id, int'(v.id));
    chk({tag, " busy after"}, int'(busy), 0);
    chk_tallies(tag, v.t[0], v.t[1], v.t[2], v.t[3]);
    vote_btn = '0; poll_open = 1; silent = 0;
  endtask
  initial begin
    int cc, bz;
    vec_t v;
    tbl[0]  = '{4'd5,  4'b0010, 4'b0010, 0,  1'b0, 1'b0, ACC, 4,  '{0, 1, 0, 0}};
    tbl[1]  = '{4'd5,  4'b0010, 4'b0010, 0,  1'b0, 1'b0, REJ, 3,  '{0, 1, 0, 0}};
    tbl[2]  = '{4'd3,  4'b0000, 4'b0000, 0,  1'b0, 1'b0, TMO, 11, '{0, 1, 0, 0}};
    tbl[3]  = '{4'd3,  4'b0001, 4'b0001, 0,  1'b0, 1'b0, ACC, 4,  '{1, 1, 0, 0}};
    tbl[4]  = '{4'd7,  4'b1000, 4'b1000, 0,  1'b1, 1'b0, ACC, 4,  '{1, 1, 0, 1}};
    tbl[5]  = '{4'd9,  4'b1100, 4'b1100, 0,  1'b0, 1'b0, TMO, 11, '{1, 1, 0, 1}};
    tbl[6]  = '{4'd9,  4'b0100, 4'b0100, 0,  1'b0, 1'b0, ACC, 4,  '{1, 1, 1, 1}};
    tbl[7]  = '{4'd11, 4'b0110, 4'b0100, 6,  1'b0, 1'b0, ACC, 7,  '{1, 1, 2, 1}};
    tbl[8]  = '{4'd12, 4'b0000, 4'b0001, 10, 1'b0, 1'b0, ACC, 11, '{2, 1, 2, 1}};
    tbl[9]  = '{4'd13, 4'b0000, 4'b0001, 11, 1'b0, 1'b0, TMO, 11, '{2, 1, 2, 1}};
    tbl[10] = '{4'd10, 4'b0001, 4'b0001, 0,  1'b0, 1'b1, REJ, 3,  '{2, 1, 2, 1}};
    repeat (2) @(negedge clk);
    chk("reset busy", int'(busy), 0);
    chk("reset chk_id", int'(chk_id), 0);
    chk("reset strobes", int'({chk_check, chk_mark_done, accepted, rejected, timed_out}), 0);
    chk_tallies("reset", 0, 0, 0, 0);
    reset = 0;
    @(negedge clk);
    for (int r = 0; r < 11; r++) run_vec($sformatf("row%0d", r), tbl[r]);
    id_in = 4'd14; id_load = 1; vote_btn = '0;
    @(negedge clk); id_load = 0;
    repeat (2) @(negedge clk);
    chk("busy in vote", int'(busy), 1);
    reset = 1;
    @(negedge clk);
    chk("reset-in-vote busy", int'(busy), 0);
    chk("reset-in-vote chk_id", int'(chk_id), 0);
    chk("reset-in-vote strobes", int'({chk_mark_done, accepted, rejected, timed_out}), 0);
    chk_tallies("reset-in-vote", 0, 0, 0, 0);
    reset = 0;
    poll_open = 0; id_in = 4'd5; id_load = 1;
    cc = 0; bz = 0;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      cc += int'(chk_check);
      bz += int'(busy);
      id_load = 0;
    end
    chk("closed poll chk_check", cc, 0);
    chk("closed poll busy", bz, 0);
    poll_open = 1;
    for (int i = 0; i < 5; i++) begin
      v = '{4'(i < 3 ? i : 2 * i - 2), 4'b0001, 4'b0001, 0, 1'b0, 1'b0, ACC, 4, '{i + 1, 0, 0, 0}};
      run_vec($sformatf("sat%0d", i), v);
    end
    tally_sel = 2'd0;
    #1;
    chk("narrow tally saturated", int'(d2_tally_q), 3);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/vote_session_ctrl.md
VOTE_SESSION_CTRL -- requirements
Module: vote_session_ctrl

Interface
REQ-001 Parameter TIMEOUT_CYCLES, default 1000, vote-window length in clk cycles (range 2..65535).
REQ-002 Parameter TALLY_W, default 8, per-candidate tally width.
REQ-003 clk  in  1  clock; all state updates on its rising edge.
REQ-004 reset  in  1  synchronous, active-high reset.
REQ-005 poll_open  in  1  level; 1 = voting session open.
REQ-006 id_load  in  1  pulse; request to start a vote for id_in.
REQ-007 id_in  in  4  voter ID.
REQ-008 vote_btn  in  4  candidate buttons, one bit per candidate.
REQ-009 chk_id  out  4  ID presented to the ID checker.
REQ-010 chk_check  out  1  check strobe to the ID checker.
REQ-011 chk_mark_done  out  1  mark-voted strobe to the ID checker.
REQ-012 chk_id_valid  in  1  checker result, ID not yet used.
REQ-013 chk_id_used  in  1  checker result, ID already used.
REQ-014 busy  out  1  high whenever state is not IDLE.
REQ-015 accepted / rejected / timed_out  out  1 each  single-cycle status pulses.
REQ-016 tally_sel  in  2  candidate select for readout.
REQ-017 tally_q  out  TALLY_W  combinational readout of the selected tally.

Function
REQ-018 The FSM SHALL have states IDLE, CHECK, RESULT, VOTE and COMMIT.
REQ-019 IDLE: id_load=1 with poll_open=1 SHALL latch id_in into the ID register and go to CHECK; id_load with poll_open=0 SHALL be ignored.
REQ-020 CHECK: chk_check SHALL be 1 for exactly this one cycle; next state is RESULT.
REQ-021 RESULT: chk_id_valid=1 SHALL go to VOTE and clear the timer; otherwise, including both results 0, SHALL pulse rejected next cycle and go to IDLE.
REQ-022 VOTE: a one-hot vote_btn SHALL increment the selected tally, pulse accepted next cycle and go to COMMIT.
REQ-023 VOTE: zero or multiple bits set on vote_btn SHALL be ignored, and the timer SHALL increment.
REQ-024 VOTE: timer reaching TIMEOUT_CYCLES-1 with no valid button SHALL pulse timed_out, go to IDLE and leave the ID unmarked.
REQ-025 A valid button in the same cycle as timer expiry SHALL win (vote counted, no timed_out).
REQ-026 COMMIT: chk_mark_done SHALL be 1 for exactly this one cycle; next state is IDLE.
REQ-027 chk_id SHALL equal the latched ID and stay stable from CHECK through COMMIT.
REQ-028 Tallies SHALL saturate at 2^TALLY_W-1; each vote adds exactly 1.
REQ-029 poll_open falling mid-session SHALL NOT abort the session in progress.
REQ-030 id_load outside IDLE SHALL be ignored; there is no queuing.
REQ-031 Latency from id_load to accepted SHALL be at least 4 cycles.

Reset
REQ-032 Reset SHALL force IDLE, clear all tallies, the timer and the ID register, and drive every output to 0.
REQ-033 Reset in any state SHALL take priority, with no mark_done or status pulse issued.

Structure
REQ-034 A shared package SHALL hold the state enum, the candidate count (4) and the ID width (4).
REQ-035 The tally bank SHALL be the sub-module vote_tally_bank.
REQ-036 vote_tally_bank SHALL provide four saturating counters with an increment enable, a one-hot select and a readout mux.

Verification
REQ-037 Fresh ID 5, then vote_btn=0010 -> chk_check at cycle 1, accepted, chk_mark_done with chk_id=5, tally[1]=1.
REQ-038 ID 5 again, checker returns used -> rejected pulse, no chk_mark_done, tallies unchanged.
REQ-039 Valid ID with no button for TIMEOUT_CYCLES cycles -> timed_out, no chk_mark_done; re-presenting the same ID is then accepted.
REQ-040 vote_btn=0110 held, then 0100 -> first value ignored, tally[2]+1 only.
REQ-041 TALLY_W=2 with 5 votes for candidate 0 -> tally_q=3.
REQ-042 Reset asserted in VOTE -> IDLE next cycle, all tallies 0; poll_open=0 with id_load -> no chk_check.
